// File: rtl/snake_pkg.sv
// Shared types and defaults for the Snake game blocks: state encoding,
// coordinate/score widths and the per-axis apple hit test.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

  localparam int COORD_W        = 10;
  localparam int LEN_W          = 10;
  localparam int SCORE_W        = 20;
  localparam int DEF_HIT_RADIUS = 4;
  localparam int DEF_SCORE_STEP = 4;
  localparam int DEF_MAX_LEN    = 100;

  // One extra sign bit keeps the difference exact right down to coordinate 0.
  function automatic logic within_radius(input logic [COORD_W-1:0] a,
                                         input logic [COORD_W-1:0] b,
                                         input int                 r);
    logic signed [COORD_W:0] diff;
    logic        [COORD_W:0] mag;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    mag  = diff[COORD_W] ? COORD_W'(0) - diff : diff;
    return int'(mag) <= r;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous button level, followed by a
// rising-edge detector that yields a single one-cycle pulse per press.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
    end
  end

  // sync_q[0] is the metastability catcher; compare the two settled stages.
  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/game_flow_controller.sv
// Snake game sequencer: IDLE/PLAY/PAUSE/OVER state machine, move-tick
// generation, apple hit / collision evaluation and length/score bookkeeping.
module game_flow_controller
  import snake_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int SCORE_STEP = DEF_SCORE_STEP,
  parameter int HIT_RADIUS = DEF_HIT_RADIUS
) (
  input  logic               clock_100Mhz,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               pause_btn,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [COORD_W-1:0] apple_x,
  input  logic [COORD_W-1:0] apple_y,
  input  logic               wall_hit,
  input  logic               self_hit,
  output logic               move_tick,
  output logic               snake_rst,
  output logic               apple_load,
  output logic               sound_req,
  output logic [LEN_W-1:0]   length,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic [1:0]         game_state
);

  localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [SCORE_W:0]  STEP_EXT = (SCORE_W + 1)'(SCORE_STEP);

  game_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;
  logic [SCORE_W:0]   score_sum;
  logic               move_tick_q, move_tick_d;
  logic               eval_pending_q, eval_pending_d;
  logic               snake_rst_q, snake_rst_d;
  logic               apple_load_q, apple_load_d;
  logic               sound_req_q, sound_req_d;

  logic start_rise, pause_rise;
  logic start_go, collide, eat;

  edge_sync u_start_sync (
    .clk     (clock_100Mhz),
    .rst_n   (reset),
    .async_i (start_btn),
    .rise_o  (start_rise)
  );

  edge_sync u_pause_sync (
    .clk     (clock_100Mhz),
    .rst_n   (reset),
    .async_i (pause_btn),
    .rise_o  (pause_rise)
  );

  assign start_go = start_rise && (state_q == ST_IDLE || state_q == ST_OVER);
  assign collide  = eval_pending_q && (wall_hit || self_hit);
  assign eat      = eval_pending_q && !collide &&
                    within_radius(head_x, apple_x, HIT_RADIUS) &&
                    within_radius(head_y, apple_y, HIT_RADIUS);

  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      length_q       <= LEN_W'(1);
      score_q        <= '0;
      high_q         <= '0;
      move_tick_q    <= 1'b0;
      eval_pending_q <= 1'b0;
      snake_rst_q    <= 1'b0;
      apple_load_q   <= 1'b0;
      sound_req_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      length_q       <= length_d;
      score_q        <= score_d;
      high_q         <= high_d;
      move_tick_q    <= move_tick_d;
      eval_pending_q <= eval_pending_d;
      snake_rst_q    <= snake_rst_d;
      apple_load_q   <= apple_load_d;
      sound_req_q    <= sound_req_d;
    end
  end

  // A collision in the eval cycle ends the game even if a pause toggles too.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (start_rise) state_d = ST_PLAY;
      ST_PLAY:          if (pause_rise) state_d = ST_PAUSE;
      ST_PAUSE:         if (pause_rise) state_d = ST_PLAY;
      default:          state_d = ST_IDLE;
    endcase
    if (collide) state_d = ST_OVER;
  end

  always_comb begin
    cnt_d     = cnt_q;
    length_d  = length_q;
    score_d   = score_q;
    high_d    = high_q;
    score_sum = {1'b0, score_q} + STEP_EXT;
    if (start_go) begin
      cnt_d    = '0;
      length_d = LEN_W'(1);
      score_d  = '0;
    end else begin
      if (state_q == ST_PLAY) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      if (eat) begin
        if (length_q < LEN_MAX) length_d = length_q + LEN_W'(1);
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (score_d > high_q) high_d = score_d;
      end
    end
    // Registered tick: high in exactly the cycle the counter sits at its last value.
    move_tick_d    = (state_d == ST_PLAY) && (cnt_d == CNT_LAST);
    eval_pending_d = move_tick_q;
    snake_rst_d    = start_go;
    apple_load_d   = start_go | eat;
    sound_req_d    = eat;
  end

  assign move_tick  = move_tick_q;
  assign snake_rst  = snake_rst_q;
  assign apple_load = apple_load_q;
  assign sound_req  = sound_req_q;
  assign length     = length_q;
  assign score      = score_q;
  assign high_score = high_q;
  assign game_state = state_q;

endmodule
